// File: rtl/code_ser_pkg.sv
// Shared types and constants for the serial code link.
//   state_t : receiver FSM states
//   CODE_W  : default code width, shared with the code transmitter
package code_ser_pkg;

    localparam int CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        HOLD
    } state_t;

endpackage

// File: rtl/shift_in_reg.sv
// Right-shifting serial-in register; new bits enter at the MSB so the first
// bit received ends up in bit 0 after WIDTH shifts.
// Ports:
//   half_clk : clock, rising edge
//   rst      : synchronous active-low reset
//   clr      : synchronous clear (wins over en)
//   en       : shift din in this cycle
//   din      : serial input bit
//   q        : current register contents
//   q_next   : value the register takes on this edge, ignoring clr
module shift_in_reg
    import code_ser_pkg::*;
#(
    parameter int WIDTH = CODE_W
) (
    input  logic             half_clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next
);

    // Exposing the shifted value lets the parent capture a completed frame on
    // the same edge that samples its last bit.
    assign q_next = en ? {din, q[WIDTH-1:1]} : q;

    always_ff @(posedge half_clk) begin
        // NOTE: the data register is reset too, so a frame never starts
        // from stale contents after reset.
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/code_deserializer.sv
// Serial-to-parallel receiver for the LSB-first code stream, with a
// valid/ack handshake and a sticky overrun flag for dropped frame starts.
// Ports:
//   half_clk  : clock, rising edge
//   rst       : synchronous active-low reset
//   start_i   : frame start, clears any partial frame
//   shift_i   : data_i is valid this cycle
//   data_i    : serial bit, LSB first
//   ack_i     : consumer accepts code_out
//   code_out  : last completed code
//   valid_o   : code_out holds an unacknowledged code
//   busy_o    : frame reception in progress
//   overrun_o : sticky, a frame start arrived while a code was unacknowledged
//   bit_cnt_o : bits received in the current frame
module code_deserializer
    import code_ser_pkg::*;
#(
    parameter int WIDTH = CODE_W
) (
    input  logic                         half_clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic                         shift_i,
    input  logic                         data_i,
    input  logic                         ack_i,
    output logic [WIDTH-1:0]             code_out,
    output logic                         valid_o,
    output logic                         busy_o,
    output logic                         overrun_o,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg, sreg_next;
    logic             sreg_clr, sreg_en, load_code, set_ovr;
    logic             last_bit;

    shift_in_reg #(.WIDTH(WIDTH)) u_sreg (
        .half_clk (half_clk),
        .rst      (rst),
        .clr      (sreg_clr),
        .en       (sreg_en),
        .din      (data_i),
        .q        (sreg),
        .q_next   (sreg_next)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        sreg_clr  = 1'b0;
        sreg_en   = 1'b0;
        load_code = 1'b0;
        set_ovr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = RECV;
                    cnt_d    = '0;
                    sreg_clr = 1'b1;
                end
            end
            RECV: begin
                // A new start restarts the frame and its data is not sampled.
                if (start_i) begin
                    cnt_d    = '0;
                    sreg_clr = 1'b1;
                end else if (shift_i) begin
                    sreg_en = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (last_bit) begin
                        load_code = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (ack_i) begin
                    cnt_d = '0;
                    if (start_i) begin
                        state_d  = RECV;
                        sreg_clr = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (start_i) begin
                    set_ovr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge half_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            code_out  <= '0;
            overrun_o <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_code) begin
                code_out <= sreg_next;
            end
            if (set_ovr) begin
                overrun_o <= 1'b1;
            end
        end
    end

    // Pure decodes of registered state: no input reaches an output
    // combinationally.
    assign valid_o   = (state_q == HOLD);
    assign busy_o    = (state_q == RECV);
    assign bit_cnt_o = cnt_q;

endmodule

// File: tb/tb_code_deserializer.sv
// Self-checking bench for code_deserializer: expected codes are queued when a
// frame is driven and compared when the DUT presents valid_o.
module tb_code_deserializer;
    import code_ser_pkg::*;

    localparam int W = CODE_W;

    logic         half_clk = 1'b0;
    logic         rst      = 1'b0;
    logic         start_i  = 1'b0;
    logic         shift_i  = 1'b0;
    logic         data_i   = 1'b0;
    logic         ack_i    = 1'b0;
    logic [W-1:0] code_out;
    logic         valid_o;
    logic         busy_o;
    logic         overrun_o;
    logic [2:0]   bit_cnt_o;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp;

    code_deserializer #(.WIDTH(W)) dut (
        .half_clk  (half_clk),
        .rst       (rst),
        .start_i   (start_i),
        .shift_i   (shift_i),
        .data_i    (data_i),
        .ack_i     (ack_i),
        .code_out  (code_out),
        .valid_o   (valid_o),
        .busy_o    (busy_o),
        .overrun_o (overrun_o),
        .bit_cnt_o (bit_cnt_o)
    );

    always #5 half_clk = ~half_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge half_clk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        shift_i = 1'b1;
        data_i  = b;
        tick();
        shift_i = 1'b0;
        data_i  = 1'b0;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic do_ack();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
    endtask

    task automatic send_code(input logic [W-1:0] c);
        for (int i = 0; i < W; i++) shift_bit(c[i]);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({code_out, valid_o, busy_o, overrun_o, bit_cnt_o} !== '0) begin
            errors++;
            $display("FAIL reset_state: code=%h valid=%b busy=%b ovr=%b cnt=%0d, want all 0",
                     code_out, valid_o, busy_o, overrun_o, bit_cnt_o);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        exp_q.push_back(4'hD);
        do_start();
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL basic_busy: got %b want 1", busy_o);
        end
        shift_bit(1); shift_bit(0); shift_bit(1); shift_bit(1);
        checks++;
        if (valid_o !== 1'b1) begin
            errors++; $display("FAIL basic_valid: got %b want 1", valid_o);
        end
        exp = exp_q.pop_front();
        checks++;
        if (code_out !== exp) begin
            errors++; $display("FAIL basic_code: got %h want %h", code_out, exp);
        end
        checks++;
        if (busy_o !== 1'b0 || bit_cnt_o !== 3'd4) begin
            errors++; $display("FAIL basic_hold: busy=%b cnt=%0d want busy=0 cnt=4", busy_o, bit_cnt_o);
        end
        shift_bit(0);  // ignored in HOLD
        checks++;
        if (code_out !== exp || valid_o !== 1'b1) begin
            errors++; $display("FAIL hold_shift: code=%h valid=%b want %h 1", code_out, valid_o, exp);
        end
        do_ack();
        checks++;
        if (valid_o !== 1'b0 || bit_cnt_o !== 3'd0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL basic_ack: valid=%b cnt=%0d busy=%b want 0 0 0", valid_o, bit_cnt_o, busy_o);
        end
        checks++;
        if (code_out !== exp) begin
            errors++; $display("FAIL code_kept: got %h want %h", code_out, exp);
        end
    endtask

    task automatic test_gaps();
        logic [W-1:0] c;
        c = 4'hD;
        exp_q.push_back(c);
        do_start();
        for (int i = 0; i < W; i++) begin
            shift_bit(c[i]);
            if (i < W - 1) begin
                tick();
                tick();
                checks++;
                if (bit_cnt_o !== 3'(i + 1) || valid_o !== 1'b0) begin
                    errors++; $display("FAIL gap_stall: cnt=%0d valid=%b want %0d 0", bit_cnt_o, valid_o, i + 1);
                end
            end
        end
        checks++;
        if (valid_o !== 1'b1) begin
            errors++; $display("FAIL gap_valid: got %b want 1", valid_o);
        end
        exp = exp_q.pop_front();
        checks++;
        if (code_out !== exp) begin
            errors++; $display("FAIL gap_code: got %h want %h", code_out, exp);
        end
        do_ack();
    endtask

    task automatic test_restart();
        exp_q.push_back(4'h8);
        do_start();
        shift_bit(1); shift_bit(1);
        // Restart with shift also high: that bit must not be sampled.
        start_i = 1'b1; shift_i = 1'b1; data_i = 1'b1;
        tick();
        start_i = 1'b0; shift_i = 1'b0; data_i = 1'b0;
        checks++;
        if (bit_cnt_o !== 3'd0 || busy_o !== 1'b1) begin
            errors++; $display("FAIL restart_cnt: cnt=%0d busy=%b want 0 1", bit_cnt_o, busy_o);
        end
        shift_bit(0); shift_bit(0); shift_bit(0); shift_bit(1);
        checks++;
        if (valid_o !== 1'b1) begin
            errors++; $display("FAIL restart_valid: got %b want 1", valid_o);
        end
        exp = exp_q.pop_front();
        checks++;
        if (code_out !== exp || overrun_o !== 1'b0) begin
            errors++; $display("FAIL restart_code: code=%h ovr=%b want %h 0", code_out, overrun_o, exp);
        end
        do_ack();
    endtask

    task automatic test_overrun();
        exp_q.push_back(4'hA);
        do_start();
        send_code(4'hA);
        exp = exp_q.pop_front();
        checks++;
        if (valid_o !== 1'b1 || code_out !== exp) begin
            errors++; $display("FAIL ovr_frame: valid=%b code=%h want 1 %h", valid_o, code_out, exp);
        end
        do_start();
        checks++;
        if (overrun_o !== 1'b1) begin
            errors++; $display("FAIL ovr_flag: got %b want 1", overrun_o);
        end
        checks++;
        if (code_out !== exp || valid_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++; $display("FAIL ovr_hold: code=%h valid=%b busy=%b want %h 1 0", code_out, valid_o, busy_o, exp);
        end
        do_ack();
        checks++;
        if (overrun_o !== 1'b1) begin
            errors++; $display("FAIL ovr_sticky: got %b want 1", overrun_o);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.push_back(4'h5);
        do_start();
        send_code(4'h5);
        exp = exp_q.pop_front();
        checks++;
        if (valid_o !== 1'b1 || code_out !== exp) begin
            errors++; $display("FAIL sa_frame: valid=%b code=%h want 1 %h", valid_o, code_out, exp);
        end
        start_i = 1'b1; ack_i = 1'b1;
        tick();
        start_i = 1'b0; ack_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || valid_o !== 1'b0 || bit_cnt_o !== 3'd0 || overrun_o !== 1'b0) begin
            errors++; $display("FAIL start_ack: busy=%b valid=%b cnt=%0d ovr=%b want 1 0 0 0",
                               busy_o, valid_o, bit_cnt_o, overrun_o);
        end
        exp_q.push_back(4'h3);
        send_code(4'h3);
        exp = exp_q.pop_front();
        checks++;
        if (valid_o !== 1'b1 || code_out !== exp) begin
            errors++; $display("FAIL sa_next: valid=%b code=%h want 1 %h", valid_o, code_out, exp);
        end
        do_ack();
    endtask

    task automatic test_reset_mid();
        do_start();
        shift_bit(1); shift_bit(1); shift_bit(1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if ({code_out, valid_o, busy_o, overrun_o, bit_cnt_o} !== '0) begin
            errors++; $display("FAIL mid_reset: code=%h valid=%b busy=%b ovr=%b cnt=%0d want all 0",
                               code_out, valid_o, busy_o, overrun_o, bit_cnt_o);
        end
        shift_bit(1);  // IDLE ignores shifts
        checks++;
        if (bit_cnt_o !== 3'd0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL idle_shift: cnt=%0d busy=%b want 0 0", bit_cnt_o, busy_o);
        end
        exp_q.push_back(4'hD);
        do_start();
        shift_bit(1);
        // rst pulses low and back high well between edges.
        shift_i = 1'b1; data_i = 1'b0;
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        tick();
        shift_i = 1'b0;
        checks++;
        if (bit_cnt_o !== 3'd2 || busy_o !== 1'b1) begin
            errors++; $display("FAIL rst_glitch: cnt=%0d busy=%b want 2 1", bit_cnt_o, busy_o);
        end
        shift_bit(1); shift_bit(1);
        exp = exp_q.pop_front();
        checks++;
        if (valid_o !== 1'b1 || code_out !== exp) begin
            errors++; $display("FAIL glitch_code: valid=%b code=%h want 1 %h", valid_o, code_out, exp);
        end
        do_ack();
    endtask

    task automatic test_loopback();
        logic [W-1:0] tx;
        for (int c = 0; c < 16; c++) begin
            tx = W'(c);
            exp_q.push_back(tx);
            do_start();
            for (int i = 0; i < W; i++) begin
                shift_bit(tx[0]);
                tx = tx >> 1;
            end
            checks++;
            if (valid_o !== 1'b1) begin
                errors++; $display("FAIL loop_valid[%0d]: got %b want 1", c, valid_o);
            end
            exp = exp_q.pop_front();
            checks++;
            if (code_out !== exp) begin
                errors++; $display("FAIL loop_code[%0d]: got %h want %h", c, code_out, exp);
            end
            do_ack();
        end
        checks++;
        if (overrun_o !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL loop_overrun: ovr=%b pending=%0d want 0 0", overrun_o, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_restart();
        test_overrun();
        test_reset_mid();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
